// File: rtl/rot_pixel_writer.sv
// Clips rotated coordinates to the framebuffer, buffers the pixels in a FIFO and issues valid/ready writes.
// Build option: define PIXEL_COLORKEY_EN to discard samples whose colour equals KEY_COLOR.
module rot_pixel_writer #(
    parameter int unsigned COLOR_W    = 8,
    parameter int unsigned FB_W_LOG2  = 7,
    parameter int unsigned FB_H_LOG2  = 7,
    parameter int unsigned CENTER_X   = 64,
    parameter int unsigned CENTER_Y   = 64,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned KEY_COLOR  = 0
) (
    input  logic                                ACLK,
    input  logic                                ARESET,
    input  logic                                CLEAR,
    input  logic                                IN_STB,
    input  logic [7:0]                          IN_X,
    input  logic [7:0]                          IN_Y,
    input  logic                                IN_INRANGE,
    input  logic [COLOR_W-1:0]                  IN_COLOR,
    output logic                                MEM_WE,
    output logic [FB_W_LOG2+FB_H_LOG2-1:0]      MEM_ADDR,
    output logic [COLOR_W-1:0]                  MEM_DATA,
    input  logic                                MEM_READY,
    output logic [$clog2(FIFO_DEPTH):0]         FIFO_LEVEL,
    output logic                                OVERFLOW,
    output logic [15:0]                         WR_COUNT,
    output logic [7:0]                          CLIP_COUNT
);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned ADW = FB_W_LOG2 + FB_H_LOG2;
    localparam int unsigned EW  = ADW + COLOR_W;

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    logic [9:0]         sx, sy;
    logic               in_ok, key_hit;
    logic               s1_vld_q, s2_vld_q;
    logic [EW-1:0]      s1_data_q, s2_data_q;
    logic [7:0]         clip_q;
    logic [EW-1:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]        lvl_q;
    logic               ovf_q;
    logic               push, push_ok, pop, full;
    state_t             state_q;
    logic               we_q, drain_q;
    logic [ADW-1:0]     addr_q;
    logic [COLOR_W-1:0] data_q;
    logic [15:0]        wr_cnt_q;
    logic [EW-1:0]      head;

    always_comb begin
        sx    = 10'(CENTER_X) + {{2{IN_X[7]}}, IN_X};
        sy    = 10'(CENTER_Y) + {{2{IN_Y[7]}}, IN_Y};
        in_ok = IN_INRANGE && (sx[9:FB_W_LOG2] == '0) && (sy[9:FB_H_LOG2] == '0);
    end

`ifdef PIXEL_COLORKEY_EN
    assign key_hit = (IN_COLOR == COLOR_W'(KEY_COLOR));
`else
    assign key_hit = 1'b0 & (IN_COLOR == COLOR_W'(KEY_COLOR));
`endif

    always_ff @(posedge ACLK) begin
        if (ARESET || CLEAR) begin
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s1_data_q <= '0;
            s2_data_q <= '0;
            clip_q    <= '0;
        end else begin
            s1_vld_q  <= IN_STB && !key_hit && in_ok;
            s1_data_q <= {sy[FB_H_LOG2-1:0], sx[FB_W_LOG2-1:0], IN_COLOR};
            s2_vld_q  <= s1_vld_q;
            s2_data_q <= s1_data_q;
            if (IN_STB && !key_hit && !in_ok && clip_q != '1)
                clip_q <= clip_q + 8'd1;
        end
    end

    // A pop frees a slot in the same edge, so a push into a full FIFO survives when paired with a pop.
    always_comb begin
        head    = mem_q[rd_ptr_q];
        full    = (lvl_q == (AW+1)'(FIFO_DEPTH));
        pop     = (lvl_q != '0) && !drain_q && !CLEAR && !ARESET
                  && ((state_q == S_IDLE) || MEM_READY);
        push    = s2_vld_q && !CLEAR && !ARESET;
        push_ok = push && (!full || pop);
    end

    always_ff @(posedge ACLK) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= s2_data_q;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET || CLEAR) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lvl_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            lvl_q <= lvl_q + (AW+1)'(push_ok) - (AW+1)'(pop);
            if (push && !push_ok)
                ovf_q <= 1'b1;
        end
    end

    // A write caught by CLEAR is held until accepted, then retired without being counted.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            drain_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            wr_cnt_q <= '0;
        end else if (CLEAR) begin
            wr_cnt_q <= '0;
            if (we_q && !MEM_READY) begin
                drain_q <= 1'b1;
            end else begin
                we_q    <= 1'b0;
                drain_q <= 1'b0;
                state_q <= S_IDLE;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        {addr_q, data_q} <= head;
                        we_q    <= 1'b1;
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (MEM_READY) begin
                        if (drain_q) begin
                            drain_q <= 1'b0;
                            we_q    <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            wr_cnt_q <= wr_cnt_q + 16'd1;
                            if (pop) begin
                                {addr_q, data_q} <= head;
                            end else begin
                                we_q    <= 1'b0;
                                state_q <= S_IDLE;
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign MEM_WE     = we_q;
    assign MEM_ADDR   = addr_q;
    assign MEM_DATA   = data_q;
    assign FIFO_LEVEL = lvl_q;
    assign OVERFLOW   = ovf_q;
    assign WR_COUNT   = wr_cnt_q;
    assign CLIP_COUNT = clip_q;
endmodule

// File: tb/tb_rot_pixel_writer.sv
// Directed self-checking bench for rot_pixel_writer with default parameters.
module tb_rot_pixel_writer;
    logic        ACLK = 1'b0;
    logic        ARESET, CLEAR, IN_STB, IN_INRANGE, MEM_READY;
    logic [7:0]  IN_X, IN_Y, IN_COLOR;
    logic        MEM_WE, OVERFLOW;
    logic [13:0] MEM_ADDR;
    logic [7:0]  MEM_DATA, CLIP_COUNT;
    logic [3:0]  FIFO_LEVEL;
    logic [15:0] WR_COUNT;

    int n_pass  = 0;
    int n_total = 0;
    int acc_cnt = 0;
    int acc0;
    logic [13:0] addr_hold;

    rot_pixel_writer #(
        .COLOR_W   (8),
        .FB_W_LOG2 (7),
        .FB_H_LOG2 (7),
        .CENTER_X  (64),
        .CENTER_Y  (64),
        .FIFO_DEPTH(8),
        .KEY_COLOR (0)
    ) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .CLEAR     (CLEAR),
        .IN_STB    (IN_STB),
        .IN_X      (IN_X),
        .IN_Y      (IN_Y),
        .IN_INRANGE(IN_INRANGE),
        .IN_COLOR  (IN_COLOR),
        .MEM_WE    (MEM_WE),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_DATA  (MEM_DATA),
        .MEM_READY (MEM_READY),
        .FIFO_LEVEL(FIFO_LEVEL),
        .OVERFLOW  (OVERFLOW),
        .WR_COUNT  (WR_COUNT),
        .CLIP_COUNT(CLIP_COUNT)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK)
        if (MEM_WE && MEM_READY) acc_cnt++;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic inr, input logic [7:0] col);
        IN_STB = 1'b1; IN_X = x; IN_Y = y; IN_INRANGE = inr; IN_COLOR = col;
        tick();
        IN_STB = 1'b0;
    endtask

    initial begin
        ARESET = 1'b1; CLEAR = 1'b0; IN_STB = 1'b0; IN_X = '0; IN_Y = '0;
        IN_INRANGE = 1'b0; IN_COLOR = '0; MEM_READY = 1'b1;
        ticks(2);
        check("rst_we", MEM_WE, 0);
        check("rst_addr", MEM_ADDR, 0);
        check("rst_data", MEM_DATA, 0);
        check("rst_level", FIFO_LEVEL, 0);
        check("rst_ovf", OVERFLOW, 0);
        check("rst_wr", WR_COUNT, 0);
        check("rst_clip", CLIP_COUNT, 0);
        ARESET = 1'b0;
        tick();

        // Centre pixel: write appears exactly three edges after the strobe edge.
        send(8'h00, 8'h00, 1'b1, 8'h5A);
        check("lat_e0", MEM_WE, 0);
        tick(); check("lat_e1", MEM_WE, 0);
        tick(); check("lat_e2", MEM_WE, 0);
        tick();
        check("lat_e3_we", MEM_WE, 1);
        check("ctr_addr", MEM_ADDR, 14'h2040);
        check("ctr_data", MEM_DATA, 8'h5A);
        tick();
        check("ctr_we_drop", MEM_WE, 0);
        check("ctr_wr", WR_COUNT, 1);

        send(8'hC0, 8'hC0, 1'b1, 8'h11);
        ticks(3);
        check("orig_addr", MEM_ADDR, 14'h0000);
        check("orig_data", MEM_DATA, 8'h11);
        tick();
        check("orig_wr", WR_COUNT, 2);

        // Right-edge column x=127, y=0 is in range.
        send(8'h3F, 8'hC0, 1'b1, 8'h12);
        ticks(3);
        check("edge_addr", MEM_ADDR, 14'h007F);
        tick();
        check("edge_wr", WR_COUNT, 3);

        acc0 = acc_cnt;
        send(8'h40, 8'h00, 1'b1, 8'h13);
        check("clip_x_cnt", CLIP_COUNT, 1);
        send(8'h00, 8'h00, 1'b0, 8'h14);
        check("clip_inr_cnt", CLIP_COUNT, 2);
        send(8'hBF, 8'h00, 1'b1, 8'h15);
        check("clip_neg_cnt", CLIP_COUNT, 3);
        ticks(5);
        check("clip_nowrite", acc_cnt, acc0);
        check("clip_wr", WR_COUNT, 3);

        CLEAR = 1'b1; tick(); CLEAR = 1'b0;
        check("clr_wr", WR_COUNT, 0);
        check("clr_clip", CLIP_COUNT, 0);

        // Stall: eight in the FIFO, one in the output register, tenth dropped.
        MEM_READY = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            IN_STB = 1'b1; IN_X = 8'(i); IN_Y = 8'h00; IN_INRANGE = 1'b1; IN_COLOR = 8'(i);
            tick();
        end
        IN_STB = 1'b0;
        ticks(3);
        check("stall_level", FIFO_LEVEL, 8);
        check("stall_ovf", OVERFLOW, 1);
        check("stall_we", MEM_WE, 1);
        check("stall_addr", MEM_ADDR, 14'h2041);
        MEM_READY = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            check("b2b_we", MEM_WE, 1);
            check("b2b_data", MEM_DATA, i);
            tick();
        end
        check("b2b_done_we", MEM_WE, 0);
        check("b2b_wr", WR_COUNT, 9);
        check("b2b_level", FIFO_LEVEL, 0);

        // Full FIFO with push and pop on the same edge.
        CLEAR = 1'b1; tick(); CLEAR = 1'b0;
        check("clr_ovf", OVERFLOW, 0);
        MEM_READY = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            IN_STB = 1'b1; IN_X = 8'h00; IN_Y = 8'h00; IN_INRANGE = 1'b1; IN_COLOR = 8'(8'h20 + i);
            tick();
        end
        IN_STB = 1'b0;
        ticks(3);
        check("full_level", FIFO_LEVEL, 8);
        check("full_ovf0", OVERFLOW, 0);
        send(8'h00, 8'h00, 1'b1, 8'h2A);
        tick();
        MEM_READY = 1'b1;
        tick();
        MEM_READY = 1'b0;
        check("pp_level", FIFO_LEVEL, 8);
        check("pp_ovf", OVERFLOW, 0);
        check("pp_data", MEM_DATA, 8'h22);
        check("pp_wr", WR_COUNT, 1);

        MEM_READY = 1'b1; ticks(3); MEM_READY = 1'b0;
        check("pre_clr_level", FIFO_LEVEL, 5);
        check("pre_clr_data", MEM_DATA, 8'h25);
        addr_hold = MEM_ADDR;

        // CLEAR during a stalled write, with a sample presented in the same cycle.
        CLEAR = 1'b1;
        IN_STB = 1'b1; IN_X = 8'h01; IN_Y = 8'h01; IN_INRANGE = 1'b1; IN_COLOR = 8'h77;
        tick();
        CLEAR = 1'b0; IN_STB = 1'b0;
        check("clrw_we", MEM_WE, 1);
        check("clrw_level", FIFO_LEVEL, 0);
        check("clrw_wr", WR_COUNT, 0);
        check("clrw_clip", CLIP_COUNT, 0);
        ticks(2);
        check("clrw_hold_we", MEM_WE, 1);
        check("clrw_hold_addr", MEM_ADDR, addr_hold);
        acc0 = acc_cnt;
        MEM_READY = 1'b1;
        tick();
        check("clrw_done_we", MEM_WE, 0);
        check("clrw_done_wr", WR_COUNT, 0);
        ticks(5);
        check("clrw_nomore", acc_cnt, acc0 + 1);
        check("clrw_idle_we", MEM_WE, 0);
        check("clrw_idle_level", FIFO_LEVEL, 0);

        // Reset during a stall drops the request at once.
        MEM_READY = 1'b0;
        send(8'h00, 8'h00, 1'b1, 8'h44);
        ticks(3);
        check("rs_we_up", MEM_WE, 1);
        ARESET = 1'b1; tick();
        check("rs_we", MEM_WE, 0);
        check("rs_addr", MEM_ADDR, 0);
        check("rs_data", MEM_DATA, 0);
        ARESET = 1'b0; MEM_READY = 1'b1;
        tick();

        for (int i = 0; i < 260; i++) begin
            IN_STB = 1'b1; IN_X = 8'h00; IN_Y = 8'h00; IN_INRANGE = 1'b0; IN_COLOR = 8'h09;
            tick();
        end
        IN_STB = 1'b0;
        check("clip_sat", CLIP_COUNT, 255);
        CLEAR = 1'b1; tick(); CLEAR = 1'b0;
        check("clip_sat_clr", CLIP_COUNT, 0);

        acc0 = acc_cnt;
        send(8'h00, 8'h00, 1'b1, 8'h00);
        send(8'h00, 8'h00, 1'b1, 8'h03);
        send(8'h00, 8'h00, 1'b1, 8'h00);
        ticks(6);
`ifdef PIXEL_COLORKEY_EN
        check("key_writes", acc_cnt, acc0 + 1);
        check("key_wr", WR_COUNT, 1);
        check("key_data", MEM_DATA, 8'h03);
`else
        check("key_writes", acc_cnt, acc0 + 3);
        check("key_wr", WR_COUNT, 3);
        check("key_data", MEM_DATA, 8'h00);
`endif
        check("key_clip", CLIP_COUNT, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
